// File: rtl/hub_pkg.sv
// Shared widths and the stage-1 to stage-2 record for the HUB normalizer.
package hub_pkg;

  localparam int M           = 24;
  localparam int E           = 8;
  localparam int SHIFT_WIDTH = $clog2(M);

  // Stage-1 result: the hidden bit has already been dropped from shifted.
  typedef struct packed {
    logic [M-1:0] shifted;
    logic [E:0]   total;
    logic [E-1:0] exp;
    logic         sign;
    logic         zero;
  } s1_t;

endpackage

// File: rtl/hub_left_shifter.sv
// Combinational left shifter feeding the normalizer's first stage.
module hub_left_shifter #(
  parameter int M           = hub_pkg::M,
  parameter int SHIFT_WIDTH = $clog2(M)
) (
  input  logic [M:0]             data,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [M:0]             shifted
);

  import hub_pkg::*;

  // Barrel shift by the already-clamped amount.
  always_comb shifted = data << shift;

endmodule

// File: rtl/hub_normalizer.sv
// Two-stage valid/ready normalizer: shift by the LZA estimate, correct a
// one-position under-estimate, then adjust the exponent and raise flags.
module hub_normalizer #(
  parameter int M           = hub_pkg::M,
  parameter int E           = hub_pkg::E,
  parameter int SHIFT_WIDTH = $clog2(M)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [M:0]             in_sum,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  input  logic [E-1:0]           in_exp,
  input  logic                   in_sign,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [M-1:0]           out_mant,
  output logic [E-1:0]           out_exp,
  output logic                   out_sign,
  output logic                   out_zero,
  output logic                   out_underflow
);

  import hub_pkg::*;

  localparam logic [SHIFT_WIDTH-1:0] M_SH = SHIFT_WIDTH'(M);

  logic [SHIFT_WIDTH-1:0] sh_clamp;
  logic [M:0]             sh_raw;
  logic                   sum_nz;
  logic                   corr;
  s1_t                    s1_d;
  s1_t                    s1_q;
  logic                   s1_valid;
  logic                   s2_valid;
  logic                   s1_adv;
  logic                   uf;
  logic [E-1:0]           exp_adj;
  logic [M-1:0]           mant_d;
  logic [E-1:0]           exp_d;

  // Handshake: in_ready depends only on registered state and out_ready.
  always_comb begin
    s1_adv   = !s2_valid || out_ready;
    in_ready = !s1_valid || s1_adv;
  end

  // Clamp the LZA estimate so over-large counts cannot wrap the shifter.
  always_comb sh_clamp = (in_shift > M_SH) ? M_SH : in_shift;

  hub_left_shifter #(
    .M           (M),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_shift (
    .data    (in_sum),
    .shift   (sh_clamp),
    .shifted (sh_raw)
  );

  // Stage-1 combinational: one-step correction and total shift count.
  always_comb begin
    s1_d          = '0;
    sum_nz        = |in_sum;
    corr          = sum_nz && !sh_raw[M];
    s1_d.shifted  = corr ? {sh_raw[M-2:0], 1'b0} : sh_raw[M-1:0];
    s1_d.total    = (E+1)'(sh_clamp) + (E+1)'(corr);
    s1_d.exp      = in_exp;
    s1_d.sign     = in_sign;
    s1_d.zero     = !sum_nz;
  end

  // Stage-1 register, loaded whenever an operation is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Stage-2 combinational: exponent adjust, zero and flush handling.
  always_comb begin
    uf      = !s1_q.zero && ({1'b0, s1_q.exp} <= s1_q.total);
    exp_adj = s1_q.exp - s1_q.total[E-1:0];
    mant_d  = '0;
    exp_d   = '0;
    if (!s1_q.zero && !uf) begin
      mant_d = s1_q.shifted;
      exp_d  = exp_adj;
    end
  end

  // Output register; holds its contents while the result is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid      <= 1'b0;
      out_mant      <= '0;
      out_exp       <= '0;
      out_sign      <= 1'b0;
      out_zero      <= 1'b0;
      out_underflow <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_mant      <= mant_d;
        out_exp       <= exp_d;
        out_sign      <= s1_q.sign;
        out_zero      <= s1_q.zero;
        out_underflow <= uf;
      end
    end
  end

  always_comb out_valid = s2_valid;

endmodule

// File: tb/tb_hub_normalizer.sv
// Directed bench for hub_normalizer with hand-computed expectations.
module tb_hub_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_sum;
  logic [4:0]  in_shift;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_zero;
  logic        out_underflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hub_normalizer #(.M(24), .E(8), .SHIFT_WIDTH(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sum        (in_sum),
    .in_shift      (in_shift),
    .in_exp        (in_exp),
    .in_sign       (in_sign),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mant      (out_mant),
    .out_exp       (out_exp),
    .out_sign      (out_sign),
    .out_zero      (out_zero),
    .out_underflow (out_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic chk_out(input string tag, input logic [23:0] mant, input logic [7:0] ex,
                         input logic sg, input logic zr, input logic ufl);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".mant"},  32'(out_mant), 32'(mant));
    chk({tag, ".exp"},   32'(out_exp), 32'(ex));
    chk({tag, ".sign"},  32'(out_sign), 32'(sg));
    chk({tag, ".zero"},  32'(out_zero), 32'(zr));
    chk({tag, ".uf"},    32'(out_underflow), 32'(ufl));
  endtask

  task automatic drive(input logic [24:0] s, input logic [4:0] sh, input logic [7:0] ex, input logic sg);
    in_valid = 1'b1;
    in_sum   = s;
    in_shift = sh;
    in_exp   = ex;
    in_sign  = sg;
  endtask

  // One operation with out_ready high; checks exact two-cycle latency.
  task automatic single(input string tag, input logic [24:0] s, input logic [4:0] sh,
                        input logic [7:0] ex, input logic sg, input logic [23:0] mant,
                        input logic [7:0] oexp, input logic zr, input logic ufl);
    @(negedge clk);
    drive(s, sh, ex, sg);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".early"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk_out(tag, mant, oexp, sg, zr, ufl);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_shift = '0; in_exp = '0; in_sign = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_mant",  32'(out_mant), 32'd0);
    chk("rst.out_exp",   32'(out_exp), 32'd0);
    chk("rst.flags",     32'({out_sign, out_zero, out_underflow}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    single("exact",    25'h0800000, 5'd1,  8'd100, 1'b0, 24'h000000, 8'd99, 1'b0, 1'b0);
    single("mispred",  25'h0400000, 5'd1,  8'd100, 1'b1, 24'h000000, 8'd98, 1'b0, 1'b0);
    single("normal",   25'h1ABCDEF, 5'd0,  8'd10,  1'b0, 24'hABCDEF, 8'd10, 1'b0, 1'b0);
    single("shift3",   25'h02B3C4D, 5'd3,  8'd50,  1'b1, 24'h59E268, 8'd47, 1'b0, 1'b0);
    single("zero",     25'h0000000, 5'd0,  8'd50,  1'b1, 24'h000000, 8'd0,  1'b1, 1'b0);
    single("uflow",    25'h0100000, 5'd4,  8'd2,   1'b0, 24'h000000, 8'd0,  1'b0, 1'b1);
    single("uf_equal", 25'h02B3C4D, 5'd3,  8'd3,   1'b0, 24'h000000, 8'd0,  1'b0, 1'b1);
    single("uf_edge",  25'h02B3C4D, 5'd3,  8'd4,   1'b0, 24'h59E268, 8'd1,  1'b0, 1'b0);
    single("clamp",    25'h0000001, 5'd31, 8'd100, 1'b0, 24'h000000, 8'd76, 1'b0, 1'b0);

    // Backpressure: three back-to-back operations against a stalled sink.
    @(negedge clk);
    out_ready = 1'b0;
    drive(25'h1ABCDEF, 5'd0, 8'd10, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("bp.ready1", 32'(in_ready), 32'd1);
    drive(25'h02B3C4D, 5'd3, 8'd50, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(25'h0400000, 5'd1, 8'd100, 1'b0);
    chk("bp.ready_low", 32'(in_ready), 32'd0);
    chk_out("bp.A0", 24'hABCDEF, 8'd10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp.hold_ready", 32'(in_ready), 32'd0);
      chk_out("bp.hold", 24'hABCDEF, 8'd10, 1'b0, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("bp.B", 24'h59E268, 8'd47, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk_out("bp.C", 24'h000000, 8'd98, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("bp.drained", 32'(out_valid), 32'd0);

    // Reset with two operations in flight.
    drive(25'h1ABCDEF, 5'd0, 8'd10, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(25'h02B3C4D, 5'd3, 8'd50, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstmid.pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid.out_valid", 32'(out_valid), 32'd0);
    chk("rstmid.out_mant",  32'(out_mant), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rstmid.stale", 32'(out_valid), 32'd0);
    end
    chk("rstmid.in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
